// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the shift-register FIFO family.
package fifo_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 4;

   // Number of bits needed to index n distinct values (0 for n <= 1).
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Width of an occupancy counter that must hold 0..depth inclusive.
   function automatic int cw_of(input int depth);
      return clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_level_counter.sv
// Up/down occupancy counter that saturates at 0 and MAX, with synchronous reset.
module fifo_level_counter
   import fifo_pkg::*;
#(
   parameter int MAX = DEFAULT_DEPTH,
   localparam int W = cw_of(MAX)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] level,
   output logic         is_zero,
   output logic         is_max
);

   logic [W-1:0] level_q;
   logic [W-1:0] level_d;

   // Next level: step up or down only when exactly one request is active and the bound allows it.
   always_comb begin
      level_d = level_q;
      if (inc && !dec && (level_q != W'(MAX))) begin
         level_d = level_q + W'(1);
      end else if (dec && !inc && (level_q != '0)) begin
         level_d = level_q - W'(1);
      end
   end

   // Occupancy register; reset empties the FIFO in one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         level_q <= '0;
      end else begin
         level_q <= level_d;
      end
   end

   assign level   = level_q;
   assign is_zero = (level_q == '0);
   assign is_max  = (level_q == W'(MAX));

endmodule

// File: rtl/srl_fifo.sv
// First-word-fall-through FIFO built from a shift register; the head sits at index level-1.
module srl_fifo
   import fifo_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int DEPTH     = DEFAULT_DEPTH,
   parameter int AF_THRESH = DEPTH - 1,
   parameter int AE_THRESH = 1,
   localparam int CW = cw_of(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full,
   output logic             almost_empty,
   output logic             almost_full,
   output logic [CW-1:0]    level,
   output logic             overflow,
   output logic             underflow,
   input  logic             clr_err
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             push_ok, pop_ok;
   logic [CW-1:0]    head_idx;

   // A push into a full FIFO is still accepted when the head leaves in the same cycle.
   assign push_ok = wr_en & (~full | rd_en);
   assign pop_ok  = rd_en & ~empty;

   fifo_level_counter #(
      .MAX (DEPTH)
   ) u_level (
      .clk     (clk),
      .reset   (reset),
      .inc     (push_ok & ~pop_ok),
      .dec     (pop_ok & ~push_ok),
      .level   (level),
      .is_zero (empty),
      .is_max  (full)
   );

   // Shift new data in at index 0; entries older than the head simply fall off the end.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (push_ok) begin
         mem_d[0] = wr_data;
         for (int i = 1; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i-1];
         end
      end
   end

   // Storage carries no reset: contents are meaningless while level says they are absent.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_q[i] <= mem_d[i];
      end
   end

   assign head_idx = level - CW'(1);

   // Head mux; forced to zero when empty so stale storage never leaks out.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!empty && (head_idx == CW'(i))) begin
            rd_data = mem_q[i];
         end
      end
   end

   // Sticky error flags: a new error wins over a clear arriving in the same cycle.
   always_comb begin
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (clr_err) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (wr_en && !push_ok) begin
         overflow_d = 1'b1;
      end
      if (rd_en && !pop_ok) begin
         underflow_d = 1'b1;
      end
   end

   // Error flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow     = overflow_q;
   assign underflow    = underflow_q;
   assign almost_empty = (int'(level) <= AE_THRESH);
   assign almost_full  = (int'(level) >= AF_THRESH);

endmodule

// File: tb/tb_srl_fifo.sv
// Directed bench for srl_fifo at WIDTH=8, DEPTH=4, default thresholds.
module tb_srl_fifo;

   logic       clk;
   logic       reset;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       empty;
   logic       full;
   logic       almost_empty;
   logic       almost_full;
   logic [2:0] level;
   logic       overflow;
   logic       underflow;
   logic       clr_err;

   int checks;
   int errors;

   srl_fifo #(
      .WIDTH (8),
      .DEPTH (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .empty        (empty),
      .full         (full),
      .almost_empty (almost_empty),
      .almost_full  (almost_full),
      .level        (level),
      .overflow     (overflow),
      .underflow    (underflow),
      .clr_err      (clr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
      $display("check %-14s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   initial begin
      logic [7:0] exp_q [$];
      checks  = 0;
      errors  = 0;
      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      rd_en   = 1'b0;
      clr_err = 1'b0;
      tick();
      tick();

      // 1: reset then idle
      reset = 1'b0;
      tick(); tick(); tick();
      chk("rst_level", 32'(level), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_ae", 32'(almost_empty), 1);
      chk("rst_af", 32'(almost_full), 0);
      chk("rst_rdata", 32'(rd_data), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_unf", 32'(underflow), 0);

      // 2: fill then drain
      wr_en = 1'b1; wr_data = 8'hA1; tick();
      chk("fwft_head", 32'(rd_data), 32'hA1);
      chk("one_level", 32'(level), 1);
      wr_data = 8'hB2; tick();
      wr_data = 8'hC3; tick();
      chk("l3_af", 32'(almost_full), 1);
      wr_data = 8'hD4; tick();
      wr_en = 1'b0;
      chk("fill_full", 32'(full), 1);
      chk("fill_level", 32'(level), 4);
      exp_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      rd_en = 1'b1;
      foreach (exp_q[i]) begin
         chk("drain_data", 32'(rd_data), 32'(exp_q[i]));
         tick();
      end
      rd_en = 1'b0;
      chk("drain_empty", 32'(empty), 1);
      chk("drain_rdata0", 32'(rd_data), 0);

      // 3: overflow, clear, push+pop while full
      wr_en = 1'b1;
      wr_data = 8'h11; tick();
      wr_data = 8'h22; tick();
      wr_data = 8'h33; tick();
      wr_data = 8'h44; tick();
      wr_data = 8'hEE; tick();
      wr_en = 1'b0;
      chk("ovf_set", 32'(overflow), 1);
      chk("ovf_level", 32'(level), 4);
      chk("ovf_head", 32'(rd_data), 32'h11);
      clr_err = 1'b1; tick(); clr_err = 1'b0;
      chk("ovf_clr", 32'(overflow), 0);
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h99; tick();
      wr_en = 1'b0;
      chk("full_pp_ovf", 32'(overflow), 0);
      chk("full_pp_lvl", 32'(level), 4);
      exp_q = '{8'h22, 8'h33, 8'h44, 8'h99};
      foreach (exp_q[i]) begin
         chk("ovf_drain", 32'(rd_data), 32'(exp_q[i]));
         tick();
      end
      rd_en = 1'b0;
      chk("ovf_empty", 32'(empty), 1);

      // 4: push+pop on empty
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h55; tick();
      wr_en = 1'b0; rd_en = 1'b0;
      chk("unf_set", 32'(underflow), 1);
      chk("unf_level", 32'(level), 1);
      chk("unf_rdata", 32'(rd_data), 32'h55);
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      chk("unf_pop_lvl", 32'(level), 0);
      // clear racing a new underflow: set wins
      rd_en = 1'b1; clr_err = 1'b1; tick(); rd_en = 1'b0;
      chk("set_over_clr", 32'(underflow), 1);
      tick(); clr_err = 1'b0;
      chk("unf_clr", 32'(underflow), 0);

      // 5: level 2, ten push+pop cycles
      wr_en = 1'b1;
      wr_data = 8'h01; tick();
      wr_data = 8'h02; tick();
      rd_en = 1'b1;
      for (int k = 0; k < 10; k++) begin
         chk("pp_head", 32'(rd_data), 32'(k + 1));
         wr_data = 8'(k + 3);
         tick();
         chk("pp_level", 32'(level), 2);
      end
      wr_en = 1'b0;
      chk("pp_tail0", 32'(rd_data), 32'h0B);
      tick();
      chk("pp_tail1", 32'(rd_data), 32'h0C);
      tick();
      rd_en = 1'b0;
      chk("pp_empty", 32'(empty), 1);
      chk("pp_no_unf", 32'(underflow), 0);

      // 6: level 3 then reset
      wr_en = 1'b1;
      wr_data = 8'h70; tick();
      wr_data = 8'h71; tick();
      wr_data = 8'h72; tick();
      wr_en = 1'b0;
      chk("l3_level", 32'(level), 3);
      chk("l3_af2", 32'(almost_full), 1);
      chk("l3_ae", 32'(almost_empty), 0);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("mid_rst_lvl", 32'(level), 0);
      chk("mid_rst_empty", 32'(empty), 1);
      chk("mid_rst_af", 32'(almost_full), 0);
      chk("mid_rst_rdata", 32'(rd_data), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
